// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 32;

  // ROM base address; the first PC fetched after reset.
  localparam logic [FETCH_ADDR_W-1:0] RESET_VECTOR = 32'hBFC0_0000;

  // Byte stride between consecutive instructions.
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small in-order FIFO of fetch entries with a flush that overrides push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned DEPTH   = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t wr_data,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == COUNT_FULL);
  assign head  = mem[rd_ptr];

  // A flush discards everything, so neither a push nor a pop takes effect.
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the storage array has no reset; occupancy alone decides whether an
  // entry is meaningful, and leaving it unreset lets it map onto plain RAM/flops
  // without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Drives the PC into a combinational instruction ROM, queues the returned
// words with their PCs, and hands them to decode over valid/ready. Handles
// boot, back-pressure, branch/jump redirects and halt.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = FETCH_ADDR_W,
  parameter int unsigned              DATA_WIDTH    = FETCH_DATA_W,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = fetch_pkg::RESET_VECTOR,
  parameter int unsigned              QUEUE_DEPTH   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  input  logic                     halt_req,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  input  logic                     out_ready,
  output logic                     halted
);

  // Entry layout follows the instance widths; matches fetch_entry_t at defaults.
  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    instr;
  } entry_t;

  fetch_state_e             state_q;
  fetch_state_e             state_d;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_q;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_d;

  entry_t push_entry;
  entry_t head;
  logic   q_full;
  logic   q_empty;
  logic   pop;
  logic   push;
  logic   redirect_act;

  assign imem_addr = fetch_pc_q;
  assign halted    = (state_q == S_HALT);

  assign out_valid = !q_empty;
  assign out_instr = q_empty ? '0 : head.instr;
  assign out_pc    = q_empty ? '0 : head.pc;

  // A pop is accepted by decode even when a redirect flushes the queue.
  assign pop = out_valid && out_ready;

  // Redirects are ignored during the boot cycle so the boot PC survives.
  assign redirect_act = redirect_valid && (state_q != S_BOOT);

  // Fetch only while running, never on a redirect, and only if a slot is
  // free now or frees up through this cycle's pop.
  assign push = (state_q == S_RUN) && !redirect_valid && (!q_full || pop);

  assign push_entry = '{pc: fetch_pc_q, instr: imem_instr};

  fetch_queue #(
    .entry_t (entry_t),
    .DEPTH   (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_act),
    .wr_data (push_entry),
    .full    (q_full),
    .empty   (q_empty),
    .head    (head)
  );

  // State and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_VECTOR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Next state and next PC; redirect outranks both halt and sequential fetch.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;

    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (!redirect_valid && halt_req) state_d = S_HALT;
      S_HALT:  if (redirect_valid) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase

    if (redirect_act) begin
      fetch_pc_d = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a queue-based reference model is
// compared against the DUT every cycle, with directed literal checks around
// boot, back-pressure, redirect, halt, PC wrap and asynchronous reset.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_instr;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic          halt_req;
  logic          out_valid;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          out_ready;
  logic          halted;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .RESET_VECTOR  (RESET_VECTOR),
    .QUEUE_DEPTH   (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .out_valid       (out_valid),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_ready       (out_ready),
    .halted          (halted)
  );

  // ROM word k (counted from the ROM base) holds the value k.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - RESET_VECTOR;
    return off >> 2;
  endfunction

  assign imem_instr = rom_word(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  fetch_entry_t  m_q[$];
  logic [AW-1:0] m_pc      = RESET_VECTOR;
  bit            m_booting = 1'b1;
  bit            m_halted  = 1'b0;

  task automatic model_reset();
    m_q.delete();
    m_pc      = RESET_VECTOR;
    m_booting = 1'b1;
    m_halted  = 1'b0;
  endtask

  task automatic model_step();
    fetch_entry_t e;
    bit popped;
    popped = (m_q.size() > 0) && out_ready;
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (redirect_valid) begin
      m_q.delete();
      m_pc     = redirect_target & ~32'h3;
      m_halted = 1'b0;
    end else begin
      if (popped) void'(m_q.pop_front());
      if (!m_halted) begin
        if (m_q.size() < DEPTH) begin
          e.pc    = m_pc;
          e.instr = rom_word(m_pc);
          m_q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
        if (halt_req) m_halted = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Per-cycle comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("imem_addr", imem_addr, m_pc);
      check("out_valid", out_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        check("out_pc", out_pc, m_q[0].pc);
        check("out_instr", out_instr, m_q[0].instr);
      end else begin
        check("out_pc_empty", out_pc, 0);
        check("out_instr_empty", out_instr, 0);
      end
      check("halted", halted, m_halted);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0] rand_target;

  initial begin
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    halt_req        = 1'b0;
    out_ready       = 1'b1;
    step();
    step();

    // Reset state.
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_imem_addr", imem_addr, 32'hBFC0_0000);
    check("rst_halted", halted, 0);

    // Boot with no back-pressure.
    rst = 1'b0;
    step();
    check("boot_no_push", out_valid, 0);
    step();
    check("boot_first_valid", out_valid, 1);
    check("boot_first_pc", out_pc, 32'hBFC0_0000);
    check("boot_first_instr", out_instr, 0);
    step();
    check("boot_pc1", out_pc, 32'hBFC0_0004);
    check("boot_instr1", out_instr, 1);
    step();
    check("boot_pc2", out_pc, 32'hBFC0_0008);
    check("boot_addr2", imem_addr, 32'hBFC0_000C);

    // Back-pressure: queue fills, PC freezes, head holds.
    out_ready = 1'b0;
    repeat (5) step();
    check("bp_addr_frozen", imem_addr, 32'hBFC0_0010);
    check("bp_head_holds", out_pc, 32'hBFC0_0008);
    out_ready = 1'b1;
    step();
    check("bp_resume0", out_pc, 32'hBFC0_000C);
    step();
    check("bp_resume1", out_pc, 32'hBFC0_0010);

    // Redirect with a full queue and a concurrent pop.
    out_ready = 1'b0;
    step();
    step();
    out_ready       = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC0_0043;
    step();
    redirect_valid = 1'b0;
    check("redir_flushed", out_valid, 0);
    check("redir_addr", imem_addr, 32'hBFC0_0040);
    step();
    check("redir_valid", out_valid, 1);
    check("redir_pc", out_pc, 32'hBFC0_0040);
    check("redir_instr", out_instr, 32'h10);

    // Halt for one cycle, then drain.
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("halt_on", halted, 1);
    repeat (3) step();
    check("halt_drained", out_valid, 0);
    check("halt_addr_frozen", imem_addr, 32'hBFC0_0048);
    check("halt_still", halted, 1);

    // Resume via redirect.
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC0_0100;
    step();
    redirect_valid = 1'b0;
    check("resume_halted", halted, 0);
    check("resume_addr", imem_addr, 32'hBFC0_0100);
    step();
    check("resume_pc", out_pc, 32'hBFC0_0100);

    // Simultaneous halt and redirect: redirect wins.
    halt_req        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC0_0200;
    step();
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    check("both_halted", halted, 0);
    check("both_addr", imem_addr, 32'hBFC0_0200);
    step();
    check("both_halted2", halted, 0);
    check("both_pc", out_pc, 32'hBFC0_0200);

    // Redirect during the boot cycle is ignored.
    rst = 1'b1;
    step();
    rst             = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_1234;
    step();
    redirect_valid = 1'b0;
    check("bootredir_addr", imem_addr, 32'hBFC0_0000);
    step();
    check("bootredir_pc", out_pc, 32'hBFC0_0000);

    // PC wrap.
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr1", imem_addr, 32'h0000_0000);
    check("wrap_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_instr", out_instr, 32'h100F_FFFF);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      halt_req       = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 2))
        0:       rand_target = $urandom;
        1:       rand_target = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: rand_target = RESET_VECTOR + ($urandom_range(0, 63) << 2);
      endcase
      redirect_target = rand_target;
      step();
    end
    redirect_valid = 1'b0;
    halt_req       = 1'b0;

    // Asynchronous reset mid-handshake.
    redirect_valid  = 1'b1;
    redirect_target = 32'hBFC0_0300;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    step();
    step();
    check("arst_pre_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_addr", imem_addr, 32'hBFC0_0000);
    check("arst_pc", out_pc, 0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
